// File: rtl/wb_grf.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// wb_grf -- write-back stage register file with commit log.
//
// Commits MEM/WB results into a 32 x 32-bit general register file. It also
// serves two combinational decode read ports. A read whose address matches
// the register being written in the same cycle returns the write data, so a
// value written now is visible to decode before the clock edge. Register 0
// is hard-wired to zero.
//
// A retire counter counts committed register writes. Each committed write is
// also pushed into a small circular-buffer log FIFO, so that a consumer can
// drain the writes in commit order. When the FIFO is full and nothing is
// popped, a new write is dropped and a sticky overflow flag is raised.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-high reset, clears all state
//   PCW           PC of the instruction in write-back
//   A3W           destination register (0 = no write)
//   WDW           write-back data
//   A1D, A2D      decode read addresses
//   RD1D, RD2D    decode read data (combinational, with bypass)
//   log_pop       consumer acknowledge of the log head
//   log_valid     log FIFO holds at least one entry
//   log_pc        head entry PC
//   log_addr      head entry destination register
//   log_data      head entry data
//   log_overflow  sticky, set when an entry was dropped
//   retire_cnt    number of committed register writes (wraps)
// ---------------------------------------------------------------------------
module wb_grf #(
    parameter int LOG_AW = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCW,
    input  logic [4:0]  A3W,
    input  logic [31:0] WDW,
    input  logic [4:0]  A1D,
    input  logic [4:0]  A2D,
    output logic [31:0] RD1D,
    output logic [31:0] RD2D,
    input  logic        log_pop,
    output logic        log_valid,
    output logic [31:0] log_pc,
    output logic [4:0]  log_addr,
    output logic [31:0] log_data,
    output logic        log_overflow,
    output logic [31:0] retire_cnt
);

    localparam int                DEPTH    = 1 << LOG_AW;
    localparam logic [LOG_AW-1:0] PTR_ONE  = (LOG_AW)'(1);
    localparam logic [LOG_AW:0]   CNT_ONE  = (LOG_AW+1)'(1);
    localparam logic [LOG_AW:0]   CNT_FULL = (LOG_AW+1)'(DEPTH);

    // Register file
    logic [31:0] grf [32];

    // Log FIFO storage and bookkeeping
    logic [31:0]       log_pc_mem   [DEPTH];
    logic [4:0]        log_addr_mem [DEPTH];
    logic [31:0]       log_data_mem [DEPTH];
    logic [LOG_AW-1:0] wr_ptr;
    logic [LOG_AW-1:0] rd_ptr;
    logic [LOG_AW:0]   cnt;
    logic [LOG_AW:0]   cnt_nxt;
    logic              overflow_q;
    logic [31:0]       retire_q;

    logic we;
    logic fifo_empty;
    logic fifo_full;
    logic do_pop;
    logic do_push;
    logic do_drop;

    // Read-port priority: register 0, then same-cycle bypass, then array.
    function automatic logic [31:0] read_port(
        input logic [4:0]  addr,
        input logic [4:0]  waddr,
        input logic        wen,
        input logic [31:0] wdata,
        input logic [31:0] stored
    );
        if (addr == 5'd0)
            return 32'd0;
        else if (wen && (addr == waddr))
            return wdata;
        else
            return stored;
    endfunction

    assign we = (A3W != 5'd0);

    always_comb begin
        RD1D = read_port(A1D, A3W, we, WDW, grf[A1D]);
        RD2D = read_port(A2D, A3W, we, WDW, grf[A2D]);
    end

    // A pop only counts when something is queued. A push into a full FIFO
    // succeeds only when the head leaves on the same edge. A push into an
    // empty FIFO always succeeds, and the pop is ignored.
    always_comb begin
        fifo_empty = (cnt == '0);
        fifo_full  = (cnt == CNT_FULL);
        do_pop     = log_pop && !fifo_empty;
        do_push    = we && (!fifo_full || do_pop);
        do_drop    = we && fifo_full && !do_pop;
        cnt_nxt    = cnt;
        case ({do_push, do_pop})
            2'b10:   cnt_nxt = cnt + CNT_ONE;
            2'b01:   cnt_nxt = cnt - CNT_ONE;
            default: cnt_nxt = cnt;
        endcase
    end

    // Register file commit; entry 0 is reset and never written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++)
                grf[i] <= '0;
        end else if (we) begin
            grf[A3W] <= WDW;
        end
    end

    // Retire counter; wraps naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            retire_q <= '0;
        else if (we)
            retire_q <= retire_q + 32'd1;
    end

    // Log FIFO. Storage is cleared on reset so the head never reads X.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                log_pc_mem[i]   <= '0;
                log_addr_mem[i] <= '0;
                log_data_mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                log_pc_mem[wr_ptr]   <= PCW;
                log_addr_mem[wr_ptr] <= A3W;
                log_data_mem[wr_ptr] <= WDW;
                wr_ptr               <= wr_ptr + PTR_ONE;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            cnt <= cnt_nxt;
            if (do_drop)
                overflow_q <= 1'b1;
        end
    end

    assign log_valid    = !fifo_empty;
    assign log_pc       = log_pc_mem[rd_ptr];
    assign log_addr     = log_addr_mem[rd_ptr];
    assign log_data     = log_data_mem[rd_ptr];
    assign log_overflow = overflow_q;
    assign retire_cnt   = retire_q;

endmodule

// File: doc/wb_grf.md
# wb_grf

Write-back end of the pipeline: consumes the MEM/WB register outputs (PCW, A3W, WDW), commits results into a 32×32-bit general register file, and serves two decode-stage read ports with same-cycle write-back bypass. It also keeps a retire counter and a small write-log FIFO so the verification bench can drain committed writes in order. It sits between the MEM/WB pipeline register and the decode stage.

## Interface
- LOG_AW, default 2: log FIFO address width; depth = 2^LOG_AW entries.

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- PCW  in  32  PC of the instruction in WB
- A3W  in  5  destination register; 0 means no write
- WDW  in  32  write-back data
- A1D  in  5  read address, port 1
- A2D  in  5  read address, port 2
- RD1D  out  32  read data, port 1 (combinational)
- RD2D  out  32  read data, port 2 (combinational)
- log_pop  in  1  consumer acknowledge of the log head
- log_valid  out  1  log FIFO not empty
- log_pc  out  32  PC of the head entry
- log_addr  out  5  register of the head entry
- log_data  out  32  data of the head entry
- log_overflow  out  1  sticky: an entry was dropped
- retire_cnt  out  32  number of committed register writes

## Operation
- Write: `we = (A3W != 0)`. On a posedge with `we` set, `grf[A3W] <= WDW`. `grf[0]` is never written and always reads as 0.
- Read, per port, with priority:
  - address 0 → 0;
  - address == A3W and `we` → WDW (bypass);
  - otherwise → `grf[addr]`.
- Retire counter: increments by 1 on every posedge with `we` set. It wraps from 0xFFFFFFFF to 0.
- Log FIFO push: on a posedge with `we` set, push {PCW, A3W, WDW}.
- Log FIFO pop: on a posedge with `log_pop && log_valid`, pop the head. A pop while empty is ignored and has no side effects.
- FIFO full, push with no pop: the new entry is dropped, the existing contents are kept, and `log_overflow` is set.
- FIFO full, push with simultaneous pop: both take effect, occupancy is unchanged, and no overflow is flagged.
- FIFO empty, push with simultaneous pop: the pop is ignored and the push takes effect.
- `log_overflow` stays set until reset.
- Head outputs are `log_pc`, `log_addr`, `log_data`. Their values are don't-care while `log_valid` = 0, but they must not be X after reset; they read as 0.
- Implementation: FIFO is a circular buffer with LOG_AW-bit read/write pointers, which wrap modulo depth, plus a (LOG_AW+1)-bit count.

## Timing
- Reset, asynchronous and effective immediately:
  - all GRF entries = 0;
  - retire_cnt = 0;
  - FIFO pointers and count = 0, so log_valid = 0;
  - log_overflow = 0;
  - log_pc, log_addr and log_data read 0.
- Reset asserted mid-operation discards any in-flight write on that edge.
- Write latency: the new value is in the array after the write edge. Readers see it in the same cycle via bypass, before that edge.
- Log latency: `log_valid` rises the cycle after the write edge when the FIFO was empty. The head updates the cycle after a pop edge.
- `retire_cnt` reflects a write one cycle after its edge.
- RD1D and RD2D are purely combinational from A1D, A2D, A3W, WDW and the array. There are no added pipeline stages.

## Test plan
- Reset then idle: assert reset asynchronously mid-cycle → RD1D/RD2D = 0 for every address, log_valid = 0, retire_cnt = 0, log_overflow = 0.
- Write then read:
  - A3W=5, WDW=0x12345678 for one cycle with A1D=5 → RD1D = 0x12345678 in the same cycle (bypass).
  - Next cycle, A3W=0 and A1D=5 → RD1D = 0x12345678 (array).
  - retire_cnt = 1.
- $0 protection: A3W=0 with WDW=0xFFFFFFFF, and A1D=A2D=0 → RD = 0, retire_cnt unchanged, no log push.
- Log order: write r1=0x11 (PC 0x3000), r2=0x22 (PC 0x3004), r3=0x33 (PC 0x3008), then pop three times → head shows (0x3000,1,0x11), then (0x3004,2,0x22), then (0x3008,3,0x33); log_valid = 0 after the third pop.
- Overflow:
  - With LOG_AW=2, do 5 writes with no pop → log_overflow = 1, and the 4 oldest entries are retained in order.
  - With the FIFO full, a write plus a pop in the same cycle → no drop, occupancy stays 4.
- Reset mid-drain: with 3 entries queued, assert reset during a write cycle → log_valid = 0, the written register reads 0, and retire_cnt = 0.
